// File: rtl/stage2_cnn_ctrl.sv
// ---------------------------------------------------------------------------
// stage2_cnn_ctrl
//   Pass scheduler for the stage-2 conv core (fixed 3-output-channel engine).
//   A frame is processed as N_PASS passes. Each pass streams the whole
//   IMG_X*IMG_Y input fmap into the core with weight group o_wgt_sel. It then
//   collects the OX*OY core results and turns them into linear
//   output-buffer write addresses.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   i_start           job start pulse (ignored unless idle)
//   i_fmap_avail      fmap buffer holds a complete frame (sampled in S_WAIT)
//   o_busy            high in every state except S_IDLE
//   o_done            one-cycle pulse at end of job
//   o_err             sticky error, cleared by i_start or reset
//   o_fmap_rd_en      fmap buffer read strobe
//   o_fmap_rd_addr    raster pixel address
//   o_core_in_valid   o_fmap_rd_en delayed by RD_LAT (core i_in_valid)
//   o_wgt_sel         weight/bias group select (= current pass)
//   i_core_ot_valid   core result strobe
//   o_wr_en           output buffer write strobe (combinational from result)
//   o_wr_addr         output buffer address, pass*OX*OY + result index
//
// The core must share this reset: its row/col counters only make sense for
// whole frames, so an aborted pass has to restart both sides together.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_IDLE   | waiting for i_start
// S_WAIT   | pass armed, waiting for a complete fmap frame
// S_STREAM | one fmap read per cycle, pixel 0 .. IMG_X*IMG_Y-1
// S_DRAIN  | waiting for the read tail and the remaining results, timeout
// S_DONE   | o_done pulse, back to idle
// ---------------------------------------------------------------------------
module stage2_cnn_ctrl #(
  parameter int IMG_X    = 12,
  parameter int IMG_Y    = 12,
  parameter int K        = 5,
  parameter int N_PASS   = 4,
  parameter int RD_LAT   = 1,
  parameter int DRAIN_TO = 64
) (
  input  logic                                             clk,
  input  logic                                             reset,
  input  logic                                             i_start,
  input  logic                                             i_fmap_avail,
  output logic                                             o_busy,
  output logic                                             o_done,
  output logic                                             o_err,
  output logic                                             o_fmap_rd_en,
  output logic [$clog2(IMG_X*IMG_Y)-1:0]                   o_fmap_rd_addr,
  output logic                                             o_core_in_valid,
  output logic [((N_PASS > 1) ? $clog2(N_PASS) : 1)-1:0]   o_wgt_sel,
  input  logic                                             i_core_ot_valid,
  output logic                                             o_wr_en,
  output logic [$clog2(N_PASS*(IMG_X-K+1)*(IMG_Y-K+1))-1:0] o_wr_addr
);

  localparam int PIX_N = IMG_X * IMG_Y;
  localparam int OX    = IMG_X - K + 1;
  localparam int OY    = IMG_Y - K + 1;
  localparam int RES_N = OX * OY;
  localparam int AW    = $clog2(PIX_N);
  localparam int PW    = (N_PASS > 1) ? $clog2(N_PASS) : 1;
  localparam int WAW   = $clog2(N_PASS * RES_N);
  localparam int PIXW  = $clog2(PIX_N + 1);
  localparam int RESW  = $clog2(RES_N + 1);
  localparam int TOW   = $clog2(DRAIN_TO + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t            state;
  logic [PIXW-1:0]   pix;
  logic [RESW-1:0]   res;
  logic [PW-1:0]     pass;
  logic [TOW-1:0]    to_cnt;
  logic [RD_LAT-1:0] dly;
  logic              collect;
  logic              wr_hit;

  // Results are accepted while streaming or draining, up to OX*OY per pass.
  assign collect = (state == S_STREAM) || (state == S_DRAIN);
  assign wr_hit  = i_core_ot_valid && collect && (res < RESW'(RES_N));

  assign o_wr_en         = wr_hit;
  assign o_wr_addr       = wr_hit ? (WAW'(pass) * WAW'(RES_N) + WAW'(res)) : '0;
  assign o_core_in_valid = dly[RD_LAT-1];
  assign o_wgt_sel       = pass;
  assign o_fmap_rd_addr  = AW'(pix);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      pix          <= '0;
      res          <= '0;
      pass         <= '0;
      to_cnt       <= '0;
      dly          <= '0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_fmap_rd_en <= 1'b0;
    end else begin
      // Read-latency shadow of the read strobe; drain also waits on it.
      dly[0] <= o_fmap_rd_en;
      for (int i = 1; i < RD_LAT; i++) dly[i] <= dly[i-1];

      o_done <= 1'b0;
      if (wr_hit) res <= res + RESW'(1);

      case (state)
        S_IDLE: begin
          if (i_start) begin
            state  <= S_WAIT;
            pass   <= '0;
            o_err  <= 1'b0;
            o_busy <= 1'b1;
          end
        end
        S_WAIT: begin
          if (i_fmap_avail) begin
            state        <= S_STREAM;
            pix          <= '0;
            res          <= '0;
            o_fmap_rd_en <= 1'b1;
          end
        end
        S_STREAM: begin
          // A frame is never cut short: leave only after the last pixel.
          if (pix == PIXW'(PIX_N - 1)) begin
            state        <= S_DRAIN;
            o_fmap_rd_en <= 1'b0;
            to_cnt       <= '0;
          end else begin
            pix <= pix + PIXW'(1);
          end
        end
        S_DRAIN: begin
          if ((res == RESW'(RES_N)) && (dly == '0)) begin
            if (pass == PW'(N_PASS - 1)) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              // Weight group only moves once the pass is fully retired.
              pass  <= pass + PW'(1);
              state <= S_WAIT;
            end
          end else if (!i_core_ot_valid && (to_cnt == TOW'(DRAIN_TO - 1))) begin
            o_err  <= 1'b1;
            state  <= S_DONE;
            o_done <= 1'b1;
          end else begin
            to_cnt <= i_core_ot_valid ? '0 : to_cnt + TOW'(1);
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
        default: begin
          state  <= S_IDLE;
          o_busy <= 1'b0;
        end
      endcase

      // Surplus or out-of-pass results are dropped and flagged; placed last
      // so the flag survives a simultaneous i_start.
      if (i_core_ot_valid && !wr_hit) o_err <= 1'b1;
    end
  end

endmodule
